// File: rtl/add_if.sv
// ---------------------------------------------------------------------------
// add_if
// Operand/result bundle for the registered adder "add".
//
// Optional feature macro: ADD_SUB_EN
//    When defined, the bundle carries the extra "sub" strobe that selects
//    a - b instead of a + b.
//
// Signals
//    in_valid   master -> slave   capture a/b (and sub) this cycle
//    a, b       master -> slave   operands, WIDTH bits
//    sub        master -> slave   1 = subtract (ADD_SUB_EN only)
//    sum        slave -> master   registered result
//    carry      slave -> master   registered carry-out of the top bit
//    overflow   slave -> master   registered signed overflow
//    out_valid  slave -> master   result registers were updated last edge
//
// Modports
//    master     operand producer (ALU control / testbench)
//    slave      the adder itself
// ---------------------------------------------------------------------------
interface add_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef ADD_SUB_EN
   logic             sub;
`endif
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;
   logic             out_valid;

`ifdef ADD_SUB_EN
   modport master (
      output in_valid, a, b, sub,
      input  sum, carry, overflow, out_valid
   );

   modport slave (
      input  in_valid, a, b, sub,
      output sum, carry, overflow, out_valid
   );
`else
   modport master (
      output in_valid, a, b,
      input  sum, carry, overflow, out_valid
   );

   modport slave (
      input  in_valid, a, b,
      output sum, carry, overflow, out_valid
   );
`endif
endinterface

// File: rtl/add.sv
// ---------------------------------------------------------------------------
// add
// Registered two's-complement adder for the processor ALU. A ripple chain
// of one-bit full adders feeds a single output register; a valid strobe
// travels alongside the data with one cycle of latency.
//
// Optional feature macro: ADD_SUB_EN
//    When defined, bus.sub = 1 turns the operation into a - b by inverting
//    b and forcing the carry-in to 1. carry = 1 then means "no borrow".
//    When undefined the block is add-only.
//
// Ports
//    clk     rising-edge clock
//    rst_n   asynchronous active-low reset; clears every output register
//    bus     add_if.slave: in_valid, a, b, (sub) in;
//            sum, carry, overflow, out_valid out
// ---------------------------------------------------------------------------
module add #(
   parameter int WIDTH = 16
) (
   input  logic   clk,
   input  logic   rst_n,
   add_if.slave   bus
);

   logic [WIDTH-1:0] bmod;
   logic             cin;
   logic [WIDTH-1:0] raw_sum;
   logic             raw_carry;
   logic             raw_overflow;
   logic             chain;

   // Operand conditioning: for subtraction the second operand is inverted
   // and the carry-in set, which forms the two's-complement negation of b
   // inside the same adder. Without the feature b passes straight through.
   always_comb begin
      bmod = bus.b;
      cin  = 1'b0;
`ifdef ADD_SUB_EN
      if (bus.sub) begin
         bmod = ~bus.b;
         cin  = 1'b1;
      end
`endif
   end

   // Ripple chain of full adders, least significant stage first. The carry
   // is threaded through a single variable so each stage sees the carry
   // produced by the stage below it. Overflow is taken from the sign bits:
   // like-signed operands producing a differently-signed result.
   always_comb begin
      raw_sum = '0;
      chain   = cin;
      for (int i = 0; i < WIDTH; i++) begin
         raw_sum[i] = bus.a[i] ^ bmod[i] ^ chain;
         chain      = (bus.a[i] & bmod[i]) | (chain & (bus.a[i] ^ bmod[i]));
      end
      raw_carry    = chain;
      raw_overflow = (bus.a[WIDTH-1] == bmod[WIDTH-1]) &&
                     (raw_sum[WIDTH-1] != bus.a[WIDTH-1]);
   end

   // Result register: updated only on a valid cycle, otherwise holds the
   // last result so a consumer may read it later. Reset clears everything
   // immediately, and an operation on the same edge as reset is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.sum      <= '0;
         bus.carry    <= 1'b0;
         bus.overflow <= 1'b0;
      end else if (bus.in_valid) begin
         bus.sum      <= raw_sum;
         bus.carry    <= raw_carry;
         bus.overflow <= raw_overflow;
      end
   end

   // Valid strobe: a plain delayed copy of in_valid, so it is high for
   // exactly the cycle following each capturing edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
      end
   end

endmodule

// File: tb/tb_add.sv
// ---------------------------------------------------------------------------
// tb_add
// Directed-vector bench for the registered adder "add". Inputs change on
// the falling edge and outputs are sampled on the following falling edge,
// one rising edge later. Expected values are packed as
// {out_valid, carry, overflow, sum}.
// Optional feature macro: ADD_SUB_EN (enables the subtraction scenario).
// ---------------------------------------------------------------------------
module tb_add;

   logic clk;
   logic rst_n;
   int   checkCount;
   int   passCount;
   logic [18:0] got;

   add_if #(.WIDTH(16)) bus ();

   add #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present one set of inputs at a falling edge and advance to the next
   // falling edge, so the registers have taken exactly one rising edge.
   task automatic applyStimulus(input logic valid, input logic [15:0] av,
                                input logic [15:0] bv, input logic subv);
      bus.in_valid = valid;
      bus.a        = av;
      bus.b        = bv;
`ifdef ADD_SUB_EN
      bus.sub      = subv;
`else
      if (subv) $display("[TB] sub requested in add-only build");
`endif
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0);
      applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
      got = {bus.out_valid, bus.carry, bus.overflow, bus.sum};
      checkCount++;
      if (got !== {1'b0, 1'b0, 1'b0, 16'h0000})
         $display("[TB] FAIL reset_state got %h expected %h", got, {3'b000, 16'h0000});
      else passCount++;
      rst_n = 1'b1;
   endtask

   task automatic test_add_basic;
      applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b0);
      got = {bus.out_valid, bus.carry, bus.overflow, bus.sum};
      checkCount++;
      if (got !== {1'b1, 1'b0, 1'b0, 16'h0002})
         $display("[TB] FAIL add_1_1 got %h expected %h", got, {3'b100, 16'h0002});
      else passCount++;

      applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0);
      got = {bus.out_valid, bus.carry, bus.overflow, bus.sum};
      checkCount++;
      if (got !== {1'b1, 1'b1, 1'b0, 16'h0000})
         $display("[TB] FAIL add_carry got %h expected %h", got, {3'b110, 16'h0000});
      else passCount++;

      applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0);
      got = {bus.out_valid, bus.carry, bus.overflow, bus.sum};
      checkCount++;
      if (got !== {1'b1, 1'b0, 1'b1, 16'h8000})
         $display("[TB] FAIL add_pos_overflow got %h expected %h", got, {3'b101, 16'h8000});
      else passCount++;
   endtask

   task automatic test_hold;
      applyStimulus(1'b1, 16'h8000, 16'h8000, 1'b0);
      got = {bus.out_valid, bus.carry, bus.overflow, bus.sum};
      checkCount++;
      if (got !== {1'b1, 1'b1, 1'b1, 16'h0000})
         $display("[TB] FAIL add_neg_overflow got %h expected %h", got, {3'b111, 16'h0000});
      else passCount++;

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 16'h5555 + 16'(i), 16'h1234, 1'b0);
         got = {bus.out_valid, bus.carry, bus.overflow, bus.sum};
         checkCount++;
         if (got !== {1'b0, 1'b1, 1'b1, 16'h0000})
            $display("[TB] FAIL hold_%0d got %h expected %h", i, got, {3'b011, 16'h0000});
         else passCount++;
      end
   endtask

   task automatic test_back_to_back;
      applyStimulus(1'b1, 16'h1234, 16'h1111, 1'b0);
      got = {bus.out_valid, bus.carry, bus.overflow, bus.sum};
      checkCount++;
      if (got !== {1'b1, 1'b0, 1'b0, 16'h2345})
         $display("[TB] FAIL b2b_first got %h expected %h", got, {3'b100, 16'h2345});
      else passCount++;

      applyStimulus(1'b1, 16'h00FF, 16'h0001, 1'b0);
      got = {bus.out_valid, bus.carry, bus.overflow, bus.sum};
      checkCount++;
      if (got !== {1'b1, 1'b0, 1'b0, 16'h0100})
         $display("[TB] FAIL b2b_second got %h expected %h", got, {3'b100, 16'h0100});
      else passCount++;
   endtask

   task automatic test_async_reset;
      applyStimulus(1'b1, 16'h1234, 16'h1111, 1'b0);
      got = {bus.out_valid, bus.carry, bus.overflow, bus.sum};
      checkCount++;
      if (got !== {1'b1, 1'b0, 1'b0, 16'h2345})
         $display("[TB] FAIL pre_reset got %h expected %h", got, {3'b100, 16'h2345});
      else passCount++;

      // Assert reset between edges: outputs must clear without a clock.
      #1 rst_n = 1'b0;
      #1;
      got = {bus.out_valid, bus.carry, bus.overflow, bus.sum};
      checkCount++;
      if (got !== {1'b0, 1'b0, 1'b0, 16'h0000})
         $display("[TB] FAIL async_clear got %h expected %h", got, {3'b000, 16'h0000});
      else passCount++;

      // An operation offered while reset is held is discarded.
      @(negedge clk);
      applyStimulus(1'b1, 16'h7777, 16'h1111, 1'b0);
      got = {bus.out_valid, bus.carry, bus.overflow, bus.sum};
      checkCount++;
      if (got !== {1'b0, 1'b0, 1'b0, 16'h0000})
         $display("[TB] FAIL reset_discard got %h expected %h", got, {3'b000, 16'h0000});
      else passCount++;

      rst_n = 1'b1;
      applyStimulus(1'b1, 16'h00FF, 16'h0001, 1'b0);
      got = {bus.out_valid, bus.carry, bus.overflow, bus.sum};
      checkCount++;
      if (got !== {1'b1, 1'b0, 1'b0, 16'h0100})
         $display("[TB] FAIL post_reset got %h expected %h", got, {3'b100, 16'h0100});
      else passCount++;
   endtask

`ifdef ADD_SUB_EN
   task automatic test_sub;
      applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b1);
      got = {bus.out_valid, bus.carry, bus.overflow, bus.sum};
      checkCount++;
      if (got !== {1'b1, 1'b0, 1'b0, 16'hFFFE})
         $display("[TB] FAIL sub_borrow got %h expected %h", got, {3'b100, 16'hFFFE});
      else passCount++;

      applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b1);
      got = {bus.out_valid, bus.carry, bus.overflow, bus.sum};
      checkCount++;
      if (got !== {1'b1, 1'b1, 1'b1, 16'h7FFF})
         $display("[TB] FAIL sub_overflow got %h expected %h", got, {3'b111, 16'h7FFF});
      else passCount++;

      applyStimulus(1'b1, 16'h0009, 16'h0003, 1'b1);
      got = {bus.out_valid, bus.carry, bus.overflow, bus.sum};
      checkCount++;
      if (got !== {1'b1, 1'b1, 1'b0, 16'h0006})
         $display("[TB] FAIL sub_no_borrow got %h expected %h", got, {3'b110, 16'h0006});
      else passCount++;
   endtask
`endif

   initial begin
      checkCount   = 0;
      passCount    = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
`ifdef ADD_SUB_EN
      bus.sub      = 1'b0;
`endif
      @(negedge clk);
      test_reset();
      test_add_basic();
      test_hold();
      test_back_to_back();
      test_async_reset();
`ifdef ADD_SUB_EN
      test_sub();
`endif
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
